// File: rtl/voice_mixer_acc.sv
// Voice mixer: accumulates NUM_VOICES signed samples per frame and emits one mixed sample.
// Optional macro VOICE_MIXER_SATURATE_EN clamps the output to the signed C_WIDTH range.

module adder #(
   parameter int C_WIDTH = 16,
   parameter int USE_CLA = 1
) (
   input  logic [C_WIDTH-1:0] a_i,
   input  logic [C_WIDTH-1:0] b_i,
   input  logic               cin_i,
   output logic [C_WIDTH-1:0] sum_o,
   output logic               cout_o
);

   logic [C_WIDTH-1:0] g;
   logic [C_WIDTH-1:0] p;
   logic [C_WIDTH:0]   c;
   logic               grp_g;
   logic               grp_p;
   logic               grp_cin;

   assign g = a_i & b_i;
   assign p = a_i ^ b_i;

   // CLA: 4-bit groups with in-group generate/propagate; carry enters a group only through grp_p.
   always_comb begin
      c       = '0;
      c[0]    = cin_i;
      grp_g   = 1'b0;
      grp_p   = 1'b0;
      grp_cin = cin_i;
      for (int unsigned j = 0; j < C_WIDTH; j++) begin
         if (USE_CLA != 0) begin
            if (j % 4 == 0) begin
               grp_g   = g[j];
               grp_p   = p[j];
               grp_cin = c[j];
            end else begin
               grp_g = g[j] | (p[j] & grp_g);
               grp_p = p[j] & grp_p;
            end
            c[j+1] = grp_g | (grp_p & grp_cin);
         end else begin
            c[j+1] = g[j] | (p[j] & c[j]);
         end
      end
   end

   assign sum_o  = p ^ c[C_WIDTH-1:0];
   assign cout_o = c[C_WIDTH];

endmodule

module voice_mixer_acc #(
   parameter int C_WIDTH    = 16,
   parameter int NUM_VOICES = 8,
   parameter int USE_CLA    = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [C_WIDTH-1:0] in_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [C_WIDTH-1:0] out_data,
   output logic               busy
);

   localparam int CNT_W = $clog2(NUM_VOICES);
   localparam int A_W   = C_WIDTH + CNT_W;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_VOICES - 1);

   typedef enum logic {
      ACCUM,
      OUTPUT
   } state_t;

   state_t             state_q;
   logic [A_W-1:0]     acc_q;
   logic [A_W-1:0]     acc_d;
   logic [A_W-1:0]     in_ext;
   logic [CNT_W-1:0]   cnt_q;
   logic [C_WIDTH-1:0] out_q;
   logic [C_WIDTH-1:0] out_d;
   logic               in_ready_q;
   logic               out_valid_q;
   logic               unused_cout;

   assign in_ext = {{(A_W-C_WIDTH){in_data[C_WIDTH-1]}}, in_data};

   adder #(
      .C_WIDTH (A_W),
      .USE_CLA (USE_CLA)
   ) u_adder (
      .a_i    (acc_q),
      .b_i    (in_ext),
      .cin_i  (1'b0),
      .sum_o  (acc_d),
      .cout_o (unused_cout)
   );

`ifdef VOICE_MIXER_SATURATE_EN
   logic [A_W-C_WIDTH:0] sum_top;
   assign sum_top = acc_d[A_W-1:C_WIDTH-1];

   // The sum fits when every bit above the output sign bit agrees with it.
   always_comb begin
      out_d = acc_d[C_WIDTH-1:0];
      if (!((sum_top == '0) || (sum_top == '1))) begin
         if (acc_d[A_W-1]) begin
            out_d = {1'b1, {(C_WIDTH-1){1'b0}}};
         end else begin
            out_d = {1'b0, {(C_WIDTH-1){1'b1}}};
         end
      end
   end
`else
   assign out_d = acc_d[C_WIDTH-1:0];
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ACCUM;
         acc_q       <= '0;
         cnt_q       <= '0;
         out_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            ACCUM: begin
               if (in_valid && in_ready_q) begin
                  acc_q <= (cnt_q == '0) ? in_ext : acc_d;
                  if (cnt_q == CNT_LAST) begin
                     out_q       <= out_d;
                     cnt_q       <= '0;
                     state_q     <= OUTPUT;
                     in_ready_q  <= 1'b0;
                     out_valid_q <= 1'b1;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
            end
            OUTPUT: begin
               if (out_ready) begin
                  state_q     <= ACCUM;
                  in_ready_q  <= 1'b1;
                  out_valid_q <= 1'b0;
               end
            end
            default: begin
               state_q     <= ACCUM;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_q;
   assign busy      = (cnt_q != '0) || (state_q == OUTPUT);

endmodule

// File: tb/tb_voice_mixer_acc.sv
// Directed bench for voice_mixer_acc (C_WIDTH=16, NUM_VOICES=8); honours VOICE_MIXER_SATURATE_EN.

module tb_voice_mixer_acc;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic        busy;

   int unsigned total_cnt = 0;
   int unsigned pass_cnt  = 0;
   int unsigned fail_cnt  = 0;

   voice_mixer_acc #(
      .C_WIDTH    (16),
      .NUM_VOICES (8),
      .USE_CLA    (1)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk1(input string tag, input logic obs, input logic exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Eight handshakes alternating a,b; out_valid must stay low until after the 8th.
   task automatic send_frame(input string tag, input logic [15:0] a, input logic [15:0] b);
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1;
         in_data  = (i % 2 == 0) ? a : b;
         step();
         if (i == 6) chk1({tag, "_pre_valid"}, out_valid, 1'b0);
      end
      in_valid = 1'b0;
   endtask

   task automatic expect_out(input string tag, input logic [15:0] exp);
      chk1({tag, "_valid"}, out_valid, 1'b1);
      chk1({tag, "_in_ready"}, in_ready, 1'b0);
      chk1({tag, "_busy"}, busy, 1'b1);
      chk16({tag, "_data"}, out_data, exp);
      step();
      chk1({tag, "_drained"}, out_valid, 1'b0);
      chk1({tag, "_idle"}, busy, 1'b0);
   endtask

   initial begin
      reset     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      step();
      step();
      chk1("rst_out_valid", out_valid, 1'b0);
      chk16("rst_out_data", out_data, 16'h0000);
      chk1("rst_busy", busy, 1'b0);
      reset = 1'b1;
      step();
      chk1("rst_in_ready", in_ready, 1'b1);

      out_ready = 1'b1;
      send_frame("basic", 16'd100, 16'd100);
      expect_out("basic", 16'd800);

      send_frame("signed", 16'd1000, 16'hF448);
      expect_out("signed", 16'hE0C0);

      send_frame("ovf_pos", 16'h7FFF, 16'h7FFF);
`ifdef VOICE_MIXER_SATURATE_EN
      expect_out("ovf_pos", 16'h7FFF);
`else
      expect_out("ovf_pos", 16'hFFF8);
`endif

      send_frame("ovf_neg", 16'h8000, 16'h8000);
`ifdef VOICE_MIXER_SATURATE_EN
      expect_out("ovf_neg", 16'h8000);
`else
      expect_out("ovf_neg", 16'h0000);
`endif

      // Backpressure: output held while in_valid stays high with a bogus sample.
      out_ready = 1'b0;
      send_frame("bp", 16'd25, 16'd25);
      in_valid = 1'b1;
      in_data  = 16'd999;
      for (int i = 0; i < 5; i++) begin
         step();
         chk1("bp_hold_valid", out_valid, 1'b1);
         chk16("bp_hold_data", out_data, 16'd200);
         chk1("bp_in_ready", in_ready, 1'b0);
      end
      in_data   = 16'd5;
      out_ready = 1'b1;
      step();
      chk1("bp_release_valid", out_valid, 1'b0);
      chk1("bp_release_in_ready", in_ready, 1'b1);
      chk1("bp_nothing_consumed", busy, 1'b0);
      send_frame("bp_next", 16'd5, 16'd5);
      expect_out("bp_next", 16'd40);

      // Partial frame of three samples discarded by an asynchronous reset.
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_data  = 16'd50;
         step();
      end
      in_valid = 1'b0;
      chk1("mid_busy_before", busy, 1'b1);
      #2;
      reset = 1'b0;
      #1;
      chk1("mid_rst_busy", busy, 1'b0);
      chk1("mid_rst_out_valid", out_valid, 1'b0);
      chk16("mid_rst_out_data", out_data, 16'h0000);
      step();
      chk1("mid_rst_busy_hold", busy, 1'b0);
      reset = 1'b1;
      step();
      send_frame("after_rst", 16'd10, 16'd10);
      expect_out("after_rst", 16'd80);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
